// File: rtl/gate_controller_pkg.sv
// Shared definitions for the parking gate controller: FSM state encodings
// and the default capacity / gate-open duration.
package gate_controller_pkg;

    // Default number of parking spaces (legal range 1..15).
    localparam int DEF_CAPACITY    = 8;
    // Default gate-open time in clk cycles: 1 s at 40 MHz.
    localparam int DEF_OPEN_CYCLES = 40000000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTRY = 2'd1,
        OPEN_EXIT  = 2'd2
    } gate_state_e;

endpackage

// File: rtl/gate_controller_edge_detector.sv
// Rising-edge detector for a debounced button level. The history register
// tracks the level even during reset, so a button held through reset
// release is never seen as a new press.
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic hist_q;

    // History follows the level every cycle, including while in reset.
    always_ff @(posedge clk) begin
        hist_q <= level;
    end

    // Rise is suppressed while reset is asserted so nothing acts on it then.
    assign rise = reset & level & ~hist_q;

endmodule

// File: rtl/gate_controller.sv
// Parking barrier controller: counts free spaces, opens the gate for a fixed
// window on an accepted entry or exit request, and flags refused entries.
module gate_controller
    import gate_controller_pkg::*;
#(
    parameter int CAPACITY    = DEF_CAPACITY,
    parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entryButton,
    input  logic       exitButton,
    output logic       gateOpen,
    output logic [3:0] freeSpaces,
    output logic       full,
    output logic       rejectPulse
);

    localparam int         TW   = $clog2(OPEN_CYCLES + 1);
    localparam logic [3:0] CAP4 = 4'(CAPACITY);
    localparam logic [TW-1:0] LAST = TW'(OPEN_CYCLES - 1);

    logic          entry_rise;
    logic          exit_rise;
    gate_state_e   state_q;
    logic [3:0]    free_q;
    logic          gate_q;
    logic          rej_q;
    logic [TW-1:0] timer_q;

    edge_detector u_entry_ed (
        .clk   (clk),
        .reset (reset),
        .level (entryButton),
        .rise  (entry_rise)
    );

    edge_detector u_exit_ed (
        .clk   (clk),
        .reset (reset),
        .level (exitButton),
        .rise  (exit_rise)
    );

    // Gate FSM: accepts requests only in IDLE, exit has priority over entry,
    // and every output it drives is registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            free_q  <= CAP4;
            gate_q  <= 1'b0;
            rej_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            rej_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (exit_rise) begin
                        // A simultaneous entry edge is dropped here.
                        if (free_q != CAP4) begin
                            free_q  <= free_q + 4'd1;
                            state_q <= OPEN_EXIT;
                            gate_q  <= 1'b1;
                        end
                    end else if (entry_rise) begin
                        if (free_q != 4'd0) begin
                            free_q  <= free_q - 4'd1;
                            state_q <= OPEN_ENTRY;
                            gate_q  <= 1'b1;
                        end else begin
                            rej_q <= 1'b1;
                        end
                    end
                end
                OPEN_ENTRY, OPEN_EXIT: begin
                    // Edges arriving here are ignored; only the timer runs.
                    if (timer_q == LAST) begin
                        state_q <= IDLE;
                        gate_q  <= 1'b0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gate_q  <= 1'b0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign gateOpen    = gate_q;
    assign freeSpaces  = free_q;
    assign full        = (free_q == 4'd0);
    assign rejectPulse = rej_q;

endmodule

// File: tb/tb_gate_controller.sv
// Directed bench for gate_controller (CAPACITY=2, OPEN_CYCLES=4). Stimulus
// queues cycle-tagged expected outputs; a negedge monitor pops and compares.
module tb_gate_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       entryButton;
    logic       exitButton;
    logic       gateOpen;
    logic [3:0] freeSpaces;
    logic       full;
    logic       rejectPulse;

    typedef struct {
        int         cyc;
        logic       go;
        logic [3:0] fs;
        logic       fl;
        logic       rj;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    gate_controller #(.CAPACITY(2), .OPEN_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .entryButton (entryButton),
        .exitButton  (exitButton),
        .gateOpen    (gateOpen),
        .freeSpaces  (freeSpaces),
        .full        (full),
        .rejectPulse (rejectPulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue an expectation d cycles from now, kept sorted by cycle.
    task automatic expect_at(input int d, input logic go, input int fs,
                             input logic rj, input string nm);
        exp_t e;
        int   i;
        e.cyc = cyc + d;
        e.go  = go;
        e.fs  = 4'(fs);
        e.fl  = (fs == 0);
        e.rj  = rj;
        e.nm  = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else if (gateOpen !== e.go || freeSpaces !== e.fs ||
                         full !== e.fl || rejectPulse !== e.rj) begin
                $display("FAIL %s @%0d: got go=%b fs=%0d full=%b rej=%b, want go=%b fs=%0d full=%b rej=%b",
                         e.nm, cyc, gateOpen, freeSpaces, full, rejectPulse,
                         e.go, e.fs, e.fl, e.rj);
            end else begin
                passes++;
            end
        end
    end

    initial begin
        int budget;
        reset       = 1'b0;
        entryButton = 1'b0;
        exitButton  = 1'b0;

        // Reset for 4 cycles, then release.
        step(4);
        expect_at(0, 1'b0, 2, 1'b0, "reset_state");
        reset = 1'b1;
        expect_at(1, 1'b0, 2, 1'b0, "after_release");
        step(2);

        // Entry held 20 cycles: one 4-cycle open window only.
        entryButton = 1'b1;
        expect_at(1,  1'b1, 1, 1'b0, "entry_open_first");
        expect_at(4,  1'b1, 1, 1'b0, "entry_open_last");
        expect_at(5,  1'b0, 1, 1'b0, "entry_closed");
        expect_at(12, 1'b0, 1, 1'b0, "held_no_retrigger");
        expect_at(20, 1'b0, 1, 1'b0, "held_still_closed");
        step(20);
        entryButton = 1'b0;
        step(2);

        // Second entry fills the lot.
        entryButton = 1'b1;
        expect_at(1, 1'b1, 0, 1'b0, "second_entry_full");
        expect_at(5, 1'b0, 0, 1'b0, "second_entry_closed");
        step(1);
        entryButton = 1'b0;
        step(6);

        // Third entry refused: one reject cycle, gate stays shut.
        entryButton = 1'b1;
        expect_at(1, 1'b0, 0, 1'b1, "reject_pulse");
        expect_at(2, 1'b0, 0, 1'b0, "reject_one_cycle");
        step(1);
        entryButton = 1'b0;
        step(3);

        // Exit from a full lot.
        exitButton = 1'b1;
        expect_at(1, 1'b1, 1, 1'b0, "exit_open");
        expect_at(5, 1'b0, 1, 1'b0, "exit_closed");
        step(1);
        exitButton = 1'b0;
        step(6);

        // Simultaneous entry and exit at freeSpaces=1: exit wins.
        entryButton = 1'b1;
        exitButton  = 1'b1;
        expect_at(1, 1'b1, 2, 1'b0, "simul_exit_served");
        expect_at(4, 1'b1, 2, 1'b0, "simul_open_last");
        expect_at(5, 1'b0, 2, 1'b0, "simul_closed");
        expect_at(6, 1'b0, 2, 1'b0, "simul_entry_dropped");
        step(1);
        entryButton = 1'b0;
        exitButton  = 1'b0;
        step(6);

        // Exit at an empty lot is ignored.
        exitButton = 1'b1;
        expect_at(1, 1'b0, 2, 1'b0, "exit_empty_ignored");
        expect_at(2, 1'b0, 2, 1'b0, "exit_empty_no_pulse");
        step(1);
        exitButton = 1'b0;
        step(2);

        // Entry press during an open window is discarded.
        entryButton = 1'b1;
        expect_at(1, 1'b1, 1, 1'b0, "win_open");
        expect_at(4, 1'b1, 1, 1'b0, "win_press_ignored");
        expect_at(5, 1'b0, 1, 1'b0, "win_closed");
        expect_at(7, 1'b0, 1, 1'b0, "win_no_second_open");
        step(1);
        entryButton = 1'b0;
        step(1);
        entryButton = 1'b1;
        step(1);
        entryButton = 1'b0;
        step(5);

        // Reset in cycle 2 of an open window with entry held through release.
        entryButton = 1'b1;
        expect_at(1, 1'b1, 0, 1'b0, "rst_win_open1");
        expect_at(2, 1'b1, 0, 1'b0, "rst_win_open2");
        expect_at(3, 1'b0, 2, 1'b0, "rst_closes_gate");
        expect_at(4, 1'b0, 2, 1'b0, "rst_held_no_trigger");
        expect_at(8, 1'b0, 2, 1'b0, "rst_still_idle");
        step(2);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(7);
        entryButton = 1'b0;

        // Drain the scoreboard with a bounded wait.
        budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            step(1);
            budget--;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
